// File: rtl/matrix_row_server.sv
// 16x16 byte matrix loaded as a byte stream, then served one 128-bit row per cycle.
// LOAD fills the matrix and accumulates a checksum; SERVE returns row[A] with one cycle of latency.
module matrix_row_server (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_valid,
  input  logic [7:0]   load_data,
  output logic         load_ready,
  input  logic         reload,
  input  logic [3:0]   A,
  output logic [127:0] Q,
  output logic         mem_ready,
  output logic [7:0]   checksum
);

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic [7:0]   k_r;
  logic [7:0]   k_nxt_s;
  logic [7:0]   checksum_r;
  logic [7:0]   checksum_nxt_s;
  logic [127:0] q_r;
  logic [127:0] q_nxt_s;
  logic         wr_en_s;
  logic [127:0] row_r [16];

  // Next-state, counter, checksum and read-data selection
  always_comb begin
    state_nxt_s    = state_r;
    k_nxt_s        = k_r;
    checksum_nxt_s = checksum_r;
    q_nxt_s        = 128'h0;
    wr_en_s        = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (load_valid) begin
          // A reset cycle must not disturb storage either
          wr_en_s        = RST;
          k_nxt_s        = k_r + 8'd1;
          checksum_nxt_s = checksum_r + load_data;
          if (k_r == 8'd255) begin
            state_nxt_s = ST_SERVE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SERVE: begin
        q_nxt_s = row_r[A];
        if (reload) begin
          state_nxt_s    = ST_LOAD;
          k_nxt_s        = 8'd0;
          checksum_nxt_s = 8'd0;
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      default: begin
        state_nxt_s    = ST_LOAD;
        k_nxt_s        = 8'd0;
        checksum_nxt_s = 8'd0;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= ST_LOAD;
      k_r        <= 8'd0;
      checksum_r <= 8'd0;
      q_r        <= 128'h0;
    end else begin
      state_r    <= state_nxt_s;
      k_r        <= k_nxt_s;
      checksum_r <= checksum_nxt_s;
      q_r        <= q_nxt_s;
    end
  end

  // Matrix storage is deliberately not reset; byte k lands in row k[7:4], lane k[3:0]
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      row_r[k_r[7:4]][{k_r[3:0], 3'b000} +: 8] <= load_data;
    end
  end

  assign load_ready = (state_r == ST_LOAD);
  assign mem_ready  = (state_r == ST_SERVE);
  assign Q          = q_r;
  assign checksum   = checksum_r;

endmodule

// File: doc/matrix_row_server.md
MATRIX_ROW_SERVER -- requirements
Module: matrix_row_server

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous and active-low (0 = reset, sampled on the CLK rising edge).
REQ-003 SHALL have port load_valid  input  1  a load byte is offered this cycle.
REQ-004 SHALL have port load_data  input  8  load byte; unsigned matrix element.
REQ-005 SHALL have port load_ready  output  1  block accepts a load byte this cycle.
REQ-006 SHALL have port reload  input  1  single-cycle request to restart matrix loading.
REQ-007 SHALL have port A  input  4  row address from the matrix-vector initiator.
REQ-008 SHALL have port Q  output  128  registered row data for the address presented in the previous cycle.
REQ-009 SHALL have port mem_ready  output  1  a complete 16x16 matrix is loaded and is being served.
REQ-010 SHALL have port checksum  output  8  modulo-256 sum of all bytes accepted since the last load start.

Function
REQ-011 SHALL store 16 rows of 16 bytes (256 x 8 bits) in internal registers.
REQ-012 SHALL implement a two-state FSM: LOAD and SERVE.
REQ-013 SHALL drive load_ready=1 only in LOAD, and mem_ready=1 only in SERVE.
REQ-014 SHALL accept a byte in any cycle where load_valid=1 and load_ready=1, and ignore load_data in every other cycle.
REQ-015 SHALL use an 8-bit byte counter k, starting at 0 on entering LOAD and incrementing by 1 per accepted byte.
REQ-016 SHALL write accepted byte k to row k[7:4], lane k[3:0], where lane j occupies Q bits [8j+7:8j].
REQ-017 SHALL add each accepted byte to checksum modulo 256 (8-bit wrap, no carry out) in the same cycle it is written.
REQ-018 SHALL, on accepting byte k=255, wrap k to 0 and enter SERVE in the next cycle; the byte written that cycle is visible in SERVE.
REQ-019 SHALL, in SERVE, register Q <= row[A] every cycle, giving exactly one cycle of read latency and allowing a new address every cycle.
REQ-020 SHALL, in LOAD, register Q <= 128'h0 every cycle, whatever the value of A.
REQ-021 SHALL, when reload=1 in SERVE, enter LOAD next cycle with k=0 and checksum=0; Q is still updated from row[A] in that cycle.
REQ-022 SHALL ignore reload in LOAD (no counter or checksum restart).
REQ-023 SHALL retain stored rows across a reload; each row is overwritten only as new bytes arrive.
REQ-024 SHALL let load_valid=1 with load_ready=0 (SERVE) have no effect on any state.
REQ-025 SHALL keep checksum constant throughout SERVE.

Reset
REQ-026 SHALL, on any cycle with RST=0, set state=LOAD, k=0, checksum=0 and Q=0, overriding load, reload and read activity in that cycle.
REQ-027 SHALL give outputs the following values in the first cycle after reset: load_ready=1, mem_ready=0, Q=0, checksum=0.
REQ-028 SHALL not clear the matrix storage on reset; its contents are undefined until loaded.
REQ-029 SHALL, on reset during LOAD or SERVE, discard the partial load and restart from k=0 once RST returns to 1.

Verification
REQ-030 SHALL cover basic load and read:
- Stimulus: after reset, stream bytes 0..255 with load_valid held at 1, then set A=3.
- Response: mem_ready=1 exactly one cycle after byte 255; one cycle after A=3, Q = bytes 63..48 (MSB..LSB), i.e. Q[7:0]=8'h30.
- Checksum: 8'h80 (sum of 0..255 mod 256).
REQ-031 SHALL cover back-to-back reads:
- Stimulus: A steps 0,1,...,15 on consecutive cycles.
- Response: Q shows rows 0..15 on cycles 1..16, one row per cycle, with no bubbles.
REQ-032 SHALL cover a gapped load:
- Stimulus: load_valid toggles 1,0,1,0 across the 256 bytes.
- Response: identical stored contents to REQ-030; mem_ready rises one cycle after the 256th accepted byte.
REQ-033 SHALL cover reload:
- Stimulus: in SERVE, reload=1 for one cycle; then load 256 bytes of 8'hFF.
- Response: load_ready=1 and Q=0 during the reload; checksum ends at 8'h00; every row then reads 128'hFF..FF.
REQ-034 SHALL cover reset mid-load:
- Stimulus: load 100 bytes, hold RST=0 for one cycle, then load 256 bytes of 8'h01.
- Response: mem_ready stays 0 until the 256th byte after reset; checksum ends at 8'h00; every row reads 16 x 8'h01.
REQ-035 SHALL cover writes outside LOAD:
- Stimulus: in SERVE, load_valid=1 with load_data=8'hAA for 10 cycles.
- Response: contents and checksum are unchanged, and load_ready stays 0.
